// File: rtl/uart_pkg.sv
// uart_pkg: transmitter state encoding, baud divisor helper and message bytes.
// Shared by uart_tx_fifo and the upstream message builder.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [7:0] MSG_HASH = 8'h23;
    localparam logic [7:0] MSG_DASH = 8'h2D;
    localparam logic [7:0] MSG_F    = 8'h46;
    localparam logic [7:0] MSG_B    = 8'h42;
    localparam logic [7:0] MSG_E    = 8'h45;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO, head word readable without a pop.
// Pointers carry one extra wrap bit so full and empty are distinct.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_wr;
    logic             w_rd;

    assign count = r_wp - r_rp;
    assign full  = (count == FULL_CNT);
    assign empty = (r_wp == r_rp);
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, back-to-back frames, tick counter.
// Define UART_TX_PARITY_EN to append an even parity bit after the payload.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_50M,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_next;
    logic [BW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_tx;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;
`ifdef UART_TX_PARITY_EN
    logic                 r_par;
`endif

    uart_byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .reset (reset),
        .push  (in_valid),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign in_ready  = !w_full;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign tx_done   = r_done;

    always_ff @(posedge clk_50M) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_tx        = 1'b1;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_end) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && r_bit == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_tx = r_par;
                if (w_bit_end) w_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // A queued byte starts its frame with no idle gap.
                if (w_bit_end && r_bit == STOP_LAST) begin
                    w_frame_end = 1'b1;
                    w_pop       = !w_empty;
                    w_next      = w_empty ? ST_IDLE : ST_START;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_busy <= (r_state != ST_IDLE) || !w_empty;
            r_done <= w_frame_end;
            if (w_pop) begin
                r_shift <= w_head;
                r_baud  <= '0;
                r_bit   <= '0;
            end else if (w_bit_end) begin
                r_baud <= '0;
                r_bit  <= (w_next != r_state) ? 4'd0 : r_bit + 4'd1;
                if (r_state == ST_DATA) r_shift <= r_shift >> 1;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_50M) begin
        if (reset)      r_par <= 1'b0;
        else if (w_pop) r_par <= ^w_head;
    end
`endif

endmodule
